// File: rtl/topk_sorter_pkg.sv
// Shared project package for the k-nearest-neighbour datapath.
// Holds the candidate entry type, its field widths, and the default list depth.
//   B         : distance width (unsigned)
//   F         : coordinate field width (x, y, z)
//   A         : point address width
//   DEFAULT_K : default number of neighbours retained
package topk_sorter_pkg;
  localparam int B         = 16;
  localparam int F         = 12;
  localparam int A         = 10;
  localparam int DEFAULT_K = 8;

  typedef struct packed {
    logic         valid;
    logic [B-1:0] distance;
    logic [F-1:0] x;
    logic [F-1:0] y;
    logic [F-1:0] z;
    logic [A-1:0] addr;
  } knn_entry_t;

  // Cleared slot: invalid, with the largest possible distance so it never
  // wins a compare against a retained entry.
  localparam knn_entry_t EMPTY_ENTRY = '{
    valid:    1'b0,
    distance: {B{1'b1}},
    x:        {F{1'b0}},
    y:        {F{1'b0}},
    z:        {F{1'b0}},
    addr:     {A{1'b0}}
  };
endpackage

// File: rtl/topk_cell.sv
// One slot of the sorted top-K list.
// Ports:
//   clock, reset   : clock, synchronous active-high reset
//   clear          : empty the slot (new query)
//   ins            : a valid candidate is being inserted this cycle
//   take_prev      : the slot above has been displaced (shift in from above)
//   new_entry      : candidate being inserted
//   prev_entry     : current content of the slot above
//   take           : candidate belongs at or above this slot
//   entry          : slot content
module topk_cell
  import topk_sorter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       ins,
  input  logic       take_prev,
  input  knn_entry_t new_entry,
  input  knn_entry_t prev_entry,
  output logic       take,
  output knn_entry_t entry
);
  // Strict less-than places a new entry after retained equal distances.
  // Because the list is sorted and empty slots sit at the tail, take is
  // monotonic down the list: the first slot with take=1 is the insertion point.
  assign take = !entry.valid || (new_entry.distance < entry.distance);

  always_ff @(posedge clock) begin
    if (reset || clear)
      entry <= EMPTY_ENTRY;
    else if (ins && take_prev)
      entry <= prev_entry;
    else if (ins && take)
      entry <= new_entry;
  end
endmodule

// File: rtl/topk_sorter.sv
// Streaming top-K sorter: keeps the K smallest-distance candidates of a
// query, sorted ascending, inserting one candidate per cycle.
// Ports:
//   clock, reset  : clock, synchronous active-high reset
//   start         : pulse, clears the list and begins a query
//   in_entry      : candidate (valid=0 is accepted but discarded)
//   in_req        : candidate presented; in_last marks the final one
//   in_ready      : block accepts candidates (ACCEPT state)
//   topk_out      : sorted list, index 0 is the nearest
//   count         : number of valid entries
//   kth_distance  : distance of slot K-1 when full, else all ones
//   done          : list final for the query; out_ack releases it
module topk_sorter
  import topk_sorter_pkg::*;
#(
  parameter int K = DEFAULT_K
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  knn_entry_t               in_entry,
  input  logic                     in_req,
  input  logic                     in_last,
  output logic                     in_ready,
  output knn_entry_t [K-1:0]       topk_out,
  output logic [$clog2(K+1)-1:0]   count,
  output logic [B-1:0]             kth_distance,
  output logic                     done,
  input  logic                     out_ack
);
  localparam int CW = $clog2(K+1);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_DONE} state_t;

  state_t             state, state_nxt;
  logic               clear, xfer, ins;
  logic [K:0]         take_chain;
  knn_entry_t [K-1:0] slots, prev_e;

  // FSM: start always wins (clears and ignores any concurrent in_req).
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    xfer      = 1'b0;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        in_ready = 1'b1;
        if (start) begin
          clear = 1'b1;
        end else if (in_req) begin
          xfer = 1'b1;
          if (in_last) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          clear     = 1'b1;
          state_nxt = S_ACCEPT;
        end else if (out_ack) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  assign ins           = xfer && in_entry.valid;
  assign take_chain[0] = 1'b0;

  generate
    for (genvar i = 0; i < K; i++) begin : g_cell
      if (i == 0) begin : g_head
        assign prev_e[i] = EMPTY_ENTRY;
      end else begin : g_body
        assign prev_e[i] = slots[i-1];
      end
      topk_cell u_cell (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .ins        (ins),
        .take_prev  (take_chain[i]),
        .new_entry  (in_entry),
        .prev_entry (prev_e[i]),
        .take       (take_chain[i+1]),
        .entry      (slots[i])
      );
    end
  endgenerate

  // The candidate lands somewhere iff the last slot would take it.
  always_ff @(posedge clock) begin
    if (reset || clear)
      count <= '0;
    else if (ins && take_chain[K] && (count != CW'(K)))
      count <= count + 1'b1;
  end

  assign topk_out     = slots;
  assign kth_distance = (count == CW'(K)) ? slots[K-1].distance : {B{1'b1}};
endmodule

// File: tb/tb_topk_sorter.sv
// Bench for topk_sorter: a K=4 and a K=8 instance share one stimulus stream.
module tb_topk_sorter;
  import topk_sorter_pkg::*;

  typedef knn_entry_t eq_t[$];

  logic               clock = 1'b0;
  logic               reset, start, in_req, in_last, out_ack;
  knn_entry_t         in_entry;
  knn_entry_t [3:0]   topk4;
  knn_entry_t [7:0]   topk8;
  logic [2:0]         cnt4;
  logic [3:0]         cnt8;
  logic [B-1:0]       kth4, kth8;
  logic               rdy4, rdy8, done4, done8;

  int n_pass  = 0;
  int n_total = 0;
  eq_t m4, m8;
  knn_entry_t empty_e;
  logic [B-1:0] ones;

  topk_sorter #(.K(4)) dut4 (
    .clock(clock), .reset(reset), .start(start), .in_entry(in_entry),
    .in_req(in_req), .in_last(in_last), .in_ready(rdy4), .topk_out(topk4),
    .count(cnt4), .kth_distance(kth4), .done(done4), .out_ack(out_ack));

  topk_sorter #(.K(8)) dut8 (
    .clock(clock), .reset(reset), .start(start), .in_entry(in_entry),
    .in_req(in_req), .in_last(in_last), .in_ready(rdy8), .topk_out(topk8),
    .count(cnt8), .kth_distance(kth8), .done(done8), .out_ack(out_ack));

  always #5 clock = ~clock;

  // Reference: stable insertion into an ascending list, truncated to k.
  function automatic eq_t ins_q(eq_t q, knn_entry_t e, int k);
    int pos = q.size();
    bit found = 0;
    if (!e.valid) return q;
    for (int i = 0; i < q.size(); i++)
      if (!found && q[i].distance > e.distance) begin
        pos = i;
        found = 1;
      end
    q.insert(pos, e);
    while (q.size() > k) void'(q.pop_back());
    return q;
  endfunction

  function automatic knn_entry_t mk(bit v, int d, int a);
    knn_entry_t e;
    e.valid    = v;
    e.distance = B'(d);
    e.x        = F'($urandom);
    e.y        = F'($urandom);
    e.z        = F'($urandom);
    e.addr     = A'(a);
    return e;
  endfunction

  task automatic send(input knn_entry_t e, input bit last);
    in_entry = e;
    in_req   = 1'b1;
    in_last  = last;
    @(posedge clock); #1;
    in_req   = 1'b0;
    in_last  = 1'b0;
    m4 = ins_q(m4, e, 4);
    m8 = ins_q(m8, e, 8);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    m4.delete();
    m8.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    n_total++;
    if ({cnt4, done4, rdy4, kth4} !== {3'd0, 1'b0, 1'b0, ones})
      $display("FAIL reset: cnt=%0d done=%b rdy=%b kth=%h", cnt4, done4, rdy4, kth4);
    else n_pass++;
    n_total++;
    if (topk8[7] !== empty_e || topk8[0] !== empty_e)
      $display("FAIL reset_slots: got %h / %h need %h", topk8[0], topk8[7], empty_e);
    else n_pass++;
  endtask

  task automatic test_sort_ties();
    int exp_d[4] = '{20, 20, 50, 80};
    int exp_a[4] = '{2, 4, 1, 3};
    do_start();
    n_total++;
    if (rdy4 !== 1'b1) $display("FAIL accept_ready: got %b need 1", rdy4);
    else n_pass++;
    send(mk(1, 50, 1), 0);
    send(mk(1, 20, 2), 0);
    send(mk(1, 80, 3), 0);
    send(mk(1, 20, 4), 1);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (topk4[i].distance !== B'(exp_d[i]) || topk4[i].addr !== A'(exp_a[i]))
        $display("FAIL ties_slot%0d: got d=%0d a=%0d need d=%0d a=%0d",
                 i, topk4[i].distance, topk4[i].addr, exp_d[i], exp_a[i]);
      else n_pass++;
    end
    n_total++;
    if ({cnt4, kth4, done4, rdy4} !== {3'd4, B'(80), 1'b1, 1'b0})
      $display("FAIL ties_status: cnt=%0d kth=%0d done=%b rdy=%b need 4 80 1 0",
               cnt4, kth4, done4, rdy4);
    else n_pass++;
  endtask

  task automatic test_full_drop();
    int exp_d[4] = '{10, 20, 25, 30};
    do_start();
    send(mk(1, 10, 1), 0);
    send(mk(1, 20, 2), 0);
    send(mk(1, 30, 3), 0);
    send(mk(1, 40, 4), 0);
    send(mk(1, 40, 5), 0);
    n_total++;
    if (cnt4 !== 3'd4 || kth4 !== B'(40) || topk4[3].addr !== A'(4))
      $display("FAIL drop_equal: cnt=%0d kth=%0d addr3=%0d need 4 40 4", cnt4, kth4, topk4[3].addr);
    else n_pass++;
    send(mk(1, 25, 6), 1);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (topk4[i].distance !== B'(exp_d[i]))
        $display("FAIL evict_slot%0d: got %0d need %0d", i, topk4[i].distance, exp_d[i]);
      else n_pass++;
    end
    n_total++;
    if (kth4 !== B'(30)) $display("FAIL evict_kth: got %0d need 30", kth4);
    else n_pass++;
    // Hold in DONE, then acknowledge: back to IDLE with the list kept.
    @(posedge clock); #1;
    n_total++;
    if (done4 !== 1'b1 || topk4[2].distance !== B'(25))
      $display("FAIL done_hold: done=%b d2=%0d need 1 25", done4, topk4[2].distance);
    else n_pass++;
    out_ack = 1'b1;
    @(posedge clock); #1;
    out_ack = 1'b0;
    n_total++;
    if ({done4, rdy4, kth4, topk4[0].distance} !== {1'b0, 1'b0, B'(30), B'(10)})
      $display("FAIL ack_idle: done=%b rdy=%b kth=%0d d0=%0d need 0 0 30 10",
               done4, rdy4, kth4, topk4[0].distance);
    else n_pass++;
  endtask

  task automatic test_invalid();
    do_start();
    send(mk(0, 5, 1), 0);
    send(mk(0, 6, 2), 0);
    n_total++;
    if (cnt4 !== 3'd0 || topk4[0] !== empty_e)
      $display("FAIL invalid_skip: cnt=%0d slot0=%h need 0 %h", cnt4, topk4[0], empty_e);
    else n_pass++;
    send(mk(1, 9, 3), 1);
    n_total++;
    if ({cnt4, kth4, topk4[0].valid, topk4[0].distance, done4} !== {3'd1, ones, 1'b1, B'(9), 1'b1})
      $display("FAIL invalid_list: cnt=%0d kth=%h v0=%b d0=%0d done=%b need 1 ffff 1 9 1",
               cnt4, kth4, topk4[0].valid, topk4[0].distance, done4);
    else n_pass++;
    n_total++;
    if (topk4[1] !== empty_e) $display("FAIL invalid_tail: got %h need %h", topk4[1], empty_e);
    else n_pass++;
  endtask

  task automatic test_start_abort();
    do_start();
    send(mk(1, 30, 1), 0);
    send(mk(1, 10, 2), 0);
    send(mk(1, 20, 3), 0);
    n_total++;
    if (cnt4 !== 3'd3) $display("FAIL abort_pre: cnt=%0d need 3", cnt4);
    else n_pass++;
    in_entry = mk(1, 1, 9);
    in_req   = 1'b1;
    do_start();
    in_req   = 1'b0;
    n_total++;
    if ({cnt4, topk4[0].valid, rdy4, done4} !== {3'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL abort_clear: cnt=%0d v0=%b rdy=%b done=%b need 0 0 1 0",
               cnt4, topk4[0].valid, rdy4, done4);
    else n_pass++;
    send(mk(1, 7, 4), 1);
    n_total++;
    if (cnt4 !== 3'd1 || topk4[0].distance !== B'(7) || topk4[0].addr !== A'(4))
      $display("FAIL abort_next: cnt=%0d d0=%0d a0=%0d need 1 7 4", cnt4, topk4[0].distance, topk4[0].addr);
    else n_pass++;
  endtask

  task automatic test_reset_in_done();
    n_total++;
    if (done4 !== 1'b1) $display("FAIL rst_pre_done: got %b need 1", done4);
    else n_pass++;
    reset   = 1'b1;
    out_ack = 1'b1;
    start   = 1'b1;
    @(posedge clock); #1;
    reset   = 1'b0;
    out_ack = 1'b0;
    start   = 1'b0;
    n_total++;
    if ({cnt4, done4, rdy4, kth4} !== {3'd0, 1'b0, 1'b0, ones})
      $display("FAIL rst_done: cnt=%0d done=%b rdy=%b kth=%h need 0 0 0 ffff", cnt4, done4, rdy4, kth4);
    else n_pass++;
  endtask

  task automatic test_random();
    knn_entry_t e4, e8;
    do_start();
    for (int n = 0; n < 1000; n++) begin
      // Idle gaps with garbage on the bus must not disturb the list.
      if ($urandom_range(0, 3) == 0) begin
        in_entry = mk(1, 0, 1023);
        @(posedge clock); #1;
      end
      send(mk($urandom_range(0, 7) != 0, $urandom_range(0, 400), n), n == 999);
      if (n % 100 == 50) begin
        n_total++;
        if (cnt8 !== 4'(m8.size()) || cnt4 !== 3'(m4.size()))
          $display("FAIL rand_count@%0d: got %0d/%0d need %0d/%0d", n, cnt8, cnt4, m8.size(), m4.size());
        else n_pass++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      e8 = (i < m8.size()) ? m8[i] : empty_e;
      n_total++;
      if (topk8[i] !== e8) $display("FAIL rand_k8_slot%0d: got %h need %h", i, topk8[i], e8);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      e4 = (i < m4.size()) ? m4[i] : empty_e;
      n_total++;
      if (topk4[i] !== e4) $display("FAIL rand_k4_slot%0d: got %h need %h", i, topk4[i], e4);
      else n_pass++;
    end
    n_total++;
    if (kth8 !== m8[7].distance || done8 !== 1'b1)
      $display("FAIL rand_kth: got %0d done=%b need %0d 1", kth8, done8, m8[7].distance);
    else n_pass++;
  endtask

  initial begin
    ones     = '1;
    empty_e  = '0;
    empty_e.distance = ones;
    reset    = 1'b0;
    start    = 1'b0;
    in_req   = 1'b0;
    in_last  = 1'b0;
    out_ack  = 1'b0;
    in_entry = '0;
    @(posedge clock); #1;
    test_reset();
    test_sort_ties();
    test_full_drop();
    test_invalid();
    test_start_abort();
    test_reset_in_done();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
